multicycle_control_unit: RTL and testbench

//  Registered, multi-cycle successor to the single-cycle control decoder for the RV32I-variant core.
//  It sequences FETCH/DECODE/EXEC/MEM/WB through an FSM, handshakes with the instruction and data memories, and drives datapath control from the latched IR.
//  It sits between the memories and the datapath (regfile, ALU, PC mux). The datapath itself is not part of this block.

---
 rtl/cu_pkg.sv | 64 ++++++
 rtl/cu_decode.sv | 70 +++++++
 rtl/multicycle_control_unit.sv | 101 ++++++++++
 tb/tb_multicycle_control_unit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared FSM states, opcodes, ALU/select encodings and decode helpers
// for the multicycle control unit.
package cu_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_EXEC_MD, S_MEM, S_WB, S_BR, S_JMP, S_TRAP
  } state_t;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_MUL  = 5'd16;
  localparam logic [3:0] SRC_REG  = 4'd0;
  localparam logic [3:0] SRC_IMM  = 4'd1;
  localparam logic [3:0] SRC_PC   = 4'd2;
  localparam logic [3:0] SRC_ZERO = 4'd3;
  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;
  localparam logic [2:0] WB_MD  = 3'd4;
  typedef struct packed {
    logic       legal, load, store, branch, jump, md;
    logic [4:0] alu;
    logic [3:0] src_a, src_b;
    logic [2:0] wb;
  } dec_t;
  typedef struct packed {
    logic       imem_req, ir_write, pc_write, branch, dmem_req, mem_write, reg_dst, reg_write, busy;
    logic [4:0] alu;
    logic [3:0] src_a, src_b;
    logic [2:0] wb;
  } out_t;
  function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  // SUB/SLT/SLTU leave zero=1 for beq/bge/bgeu taken, zero=0 for bne/blt/bltu taken
  function automatic logic br_taken(input logic [2:0] f3, input logic zero);
    return zero ^ f3[2] ^ f3[0];
  endfunction
endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational IR field -> control-vector lookup.
// MULTICYCLE_MULDIV_EN enables the M-extension (funct7=0000001) path; otherwise it decodes as illegal.
module cu_decode
  import cu_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  output dec_t       dec
);
  logic r_ok, i_ok, md;
  always_comb begin
    r_ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    i_ok = f3 == 3'b001 ? f7 == 7'b0 : f3 != 3'b101 || f7 == 7'b0 || f7 == 7'b0100000;
`ifdef MULTICYCLE_MULDIV_EN
    md = op == OP_R && f7 == 7'b0000001;
`else
    md = 1'b0;
`endif
    dec = '0;
    case (op)
      OP_R: begin
        dec.legal = r_ok || md;
        dec.md    = md;
        dec.alu   = md ? {ALU_MUL[4:3], f3} : alu_f3(f3, f7[5]);
        dec.wb    = md ? WB_MD : WB_ALU;
      end
      OP_I: begin
        dec.legal = i_ok;
        dec.alu   = alu_f3(f3, f3 == 3'b101 && f7[5]);
        dec.src_b = SRC_IMM;
      end
      OP_LUI: begin
        dec.legal = 1'b1;
        dec.src_a = SRC_ZERO;
        dec.src_b = SRC_IMM;
        dec.wb    = WB_IMM;
      end
      OP_AUIPC: begin
        dec.legal = 1'b1;
        dec.src_a = SRC_PC;
        dec.src_b = SRC_IMM;
      end
      OP_LOAD: begin
        dec.legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.load  = 1'b1;
        dec.src_b = SRC_IMM;
        dec.wb    = WB_MEM;
      end
      OP_STORE: begin
        dec.legal = f3 inside {3'b000, 3'b001, 3'b010};
        dec.store = 1'b1;
        dec.src_b = SRC_IMM;
      end
      OP_BR: begin
        dec.legal  = f3[2:1] != 2'b01;
        dec.branch = 1'b1;
        dec.alu    = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
      end
      OP_JAL, OP_JALR: begin
        dec.legal = op == OP_JAL || f3 == 3'b000;
        dec.jump  = 1'b1;
        dec.src_a = op == OP_JAL ? SRC_PC : SRC_REG;
        dec.src_b = SRC_IMM;
        dec.wb    = WB_PC4;
      end
      default: dec.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with registered control outputs.
// MULTICYCLE_MULDIV_EN (see cu_decode) adds the EXEC_MD multi-cycle MUL/DIV state.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ALUCTRL_W  = 5,
  parameter int SRC_W      = 4,
  parameter int MEMTOREG_W = 3,
  parameter int MD_CYCLES  = 32
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       instr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic                  dmem_ack,
  input  logic                  zero,
  output logic                  dmem_req,
  output logic                  MemWrite,
  output logic                  PCWrite,
  output logic                  Branch,
  output logic                  IRWrite,
  output logic [ALUCTRL_W-1:0]  ALUControl,
  output logic [SRC_W-1:0]      ALUSrc,
  output logic [SRC_W-1:0]      DataSrc,
  output logic [MEMTOREG_W-1:0] MemtoReg,
  output logic                  RegDst,
  output logic                  RegWrite,
  output logic                  illegal,
  output logic                  busy
);
  localparam int CNT_W = $clog2(MD_CYCLES + 1);
  state_t           state, next;
  logic [XLEN-1:0]  ir;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  out_t             out_q, out_d;
  logic             exe, wr, unused_ir;
  cu_decode u_decode (.op(ir[6:0]), .f3(ir[14:12]), .f7(ir[31:25]), .dec(dec));
  assign unused_ir = ^ir[24:15];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_FETCH;
      ir      <= '0;
      cnt     <= '0;
      illegal <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= next;
      ir      <= next == S_DECODE ? instr : ir;
      cnt     <= state == S_EXEC ? CNT_W'(MD_CYCLES - 1) : state == S_EXEC_MD ? cnt - CNT_W'(1) : cnt;
      illegal <= illegal | (next == S_TRAP);
      out_q   <= out_d;
    end
  // Handshakes only count while our own registered request is up; stray acks are ignored.
  always_comb begin
    next = state;
    case (state)
      S_FETCH:          next = out_q.imem_req && imem_ack ? S_DECODE : S_FETCH;
      S_DECODE:         next = !dec.legal ? S_TRAP : dec.branch ? S_BR : dec.jump ? S_JMP : S_EXEC;
      S_EXEC:           next = dec.md ? S_EXEC_MD : dec.load || dec.store ? S_MEM : S_WB;
      S_EXEC_MD:        next = cnt == '0 ? S_WB : S_EXEC_MD;
      S_MEM:            next = !(out_q.dmem_req && dmem_ack) ? S_MEM : dec.store ? S_FETCH : S_WB;
      S_WB, S_BR, S_JMP: next = S_FETCH;
      default:          next = state;
    endcase
  end
  // Outputs are decoded from the state being entered so they are registered yet aligned with it.
  always_comb begin
    exe             = next inside {S_EXEC, S_EXEC_MD, S_BR, S_JMP};
    wr              = next == S_WB || next == S_JMP;
    out_d           = '0;
    out_d.imem_req  = next == S_FETCH;
    out_d.ir_write  = next == S_DECODE;
    out_d.pc_write  = next == S_DECODE || next == S_JMP;
    out_d.branch    = next == S_BR;
    out_d.dmem_req  = next == S_MEM;
    out_d.mem_write = next == S_MEM && dec.store;
    out_d.alu       = exe ? dec.alu : ALU_ADD;
    out_d.src_a     = exe ? dec.src_a : SRC_REG;
    out_d.src_b     = exe ? dec.src_b : SRC_REG;
    out_d.wb        = wr ? dec.wb : WB_ALU;
    out_d.reg_dst   = wr && ir[11:7] != 5'd0;
    out_d.reg_write = wr && ir[11:7] != 5'd0;
    out_d.busy      = next != S_FETCH;
  end
  assign imem_req   = out_q.imem_req;
  assign dmem_req   = out_q.dmem_req;
  assign MemWrite   = out_q.mem_write;
  assign PCWrite    = out_q.pc_write | (out_q.branch & br_taken(ir[14:12], zero));
  assign Branch     = out_q.branch;
  assign IRWrite    = out_q.ir_write;
  assign ALUControl = out_q.alu;
  assign ALUSrc     = out_q.src_b;
  assign DataSrc    = out_q.src_a;
  assign MemtoReg   = out_q.wb;
  assign RegDst     = out_q.reg_dst;
  assign RegWrite   = out_q.reg_write;
  assign busy       = out_q.busy;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; per-instruction expectations are queued
// when an instruction is fetched and compared once the unit returns to FETCH (or times out).
module tb_multicycle_control_unit;
  import cu_pkg::*;
  localparam int MD_CYC = 4;
  typedef struct {
    int          lat;
    int          rw;
    logic [2:0]  wb;
    logic        rd;
    logic [31:0] pcw;
    logic [4:0]  alu;
    int          dreq;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
  logic        imem_req, dmem_req, MemWrite, PCWrite, Branch, IRWrite, RegDst, RegWrite, illegal, busy;
  logic [4:0]  ALUControl;
  logic [3:0]  ALUSrc, DataSrc;
  logic [2:0]  MemtoReg;
  int          checks = 0, errors = 0;
  exp_t        sb[$];
  multicycle_control_unit #(.MD_CYCLES(MD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .zero(zero), .dmem_req(dmem_req), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .DataSrc(DataSrc), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .illegal(illegal), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [31:0] in, input int dw, input logic z);
    exp_t e;
    logic wr;
    e = '{lat: 4, rw: 0, wb: WB_ALU, rd: 1'b0, pcw: 32'b100, alu: ALU_ADD, dreq: 0, ill: 1'b0};
    wr = 1'b1;
    case (in[6:0])
      7'b0110011:
        if (in[31:25] == 7'b0000001) begin
`ifdef MULTICYCLE_MULDIV_EN
          e.lat = 4 + MD_CYC;
          e.wb  = WB_MD;
          e.alu = ALU_MUL;
`else
          e.lat = -1;
          e.ill = 1'b1;
          wr    = 1'b0;
`endif
        end else e.alu = in[30] ? ALU_SUB : ALU_ADD;
      7'b0010011: e.alu = ALU_ADD;
      7'b0110111: e.wb = WB_IMM;
      7'b0000011: begin e.lat = 5 + dw; e.dreq = 1 + dw; e.wb = WB_MEM; end
      7'b0100011: begin e.lat = 4 + dw; e.dreq = 1 + dw; wr = 1'b0; end
      7'b1100011: begin
        e.lat = 3;
        e.alu = ALU_SUB;
        wr    = 1'b0;
        if ((in[14:12] == 3'b000) ? z : !z) e.pcw = 32'b1100;
      end
      7'b1101111: begin e.lat = 3; e.wb = WB_PC4; e.pcw = 32'b1100; end
      default: begin e.lat = -1; e.ill = 1'b1; wr = 1'b0; end
    endcase
    e.rd = wr && in[11:7] != 5'd0;
    e.rw = e.rd ? e.lat : 0;
    if (!e.rd) e.wb = WB_ALU;
    return e;
  endfunction
  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({imem_req, dmem_req, MemWrite, PCWrite, Branch, IRWrite, ALUControl,
          ALUSrc, DataSrc, MemtoReg, RegDst, RegWrite, illegal, busy}), 32'd0);
    rst_n = 1'b1;
    #1 check("imem_req before first edge", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("imem_req after first edge", 32'(imem_req), 32'd1);
    check("stray ack ignored", 32'({IRWrite, busy}), 32'd0);
    imem_ack = 1'b0;
  endtask
  task automatic run(input logic [31:0] in, input int dw, input logic z);
    exp_t e, g;
    int   w, dseen;
    g = '{lat: -1, rw: 0, wb: 3'd0, rd: 1'b0, pcw: 32'd0, alu: 5'd0, dreq: 0, ill: 1'b0};
    w = 0;
    dseen = 0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    sb.push_back(model(in, dw, z));
    zero = z;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1 && imem_req) begin
        g.lat = n - 1;
        break;
      end
      imem_ack = n == 1;
      instr    = n == 1 ? in : 32'hDEADBEEF;
      dmem_ack = dmem_req && dseen >= dw;
      dseen   += int'(dmem_req);
      #1;
      if (RegWrite && g.rw == 0) begin
        g.rw = n;
        g.wb = MemtoReg;
      end
      g.rd |= RegDst;
      if (PCWrite && n < 32) g.pcw[n] = 1'b1;
      if (n == 3) g.alu = ALUControl;
      g.dreq += int'(dmem_req);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    g.ill = illegal;
    e = sb.pop_front();
    check($sformatf("%h latency", in), 32'(g.lat), 32'(e.lat));
    check($sformatf("%h regwrite cycle", in), 32'(g.rw), 32'(e.rw));
    check($sformatf("%h memtoreg", in), 32'(g.wb), 32'(e.wb));
    check($sformatf("%h regdst", in), 32'(g.rd), 32'(e.rd));
    check($sformatf("%h pcwrite cycles", in), g.pcw, e.pcw);
    check($sformatf("%h alucontrol", in), 32'(g.alu), 32'(e.alu));
    check($sformatf("%h dmem_req cycles", in), 32'(g.dreq), 32'(e.dreq));
    check($sformatf("%h illegal", in), 32'(g.ill), 32'(e.ill));
  endtask
  initial begin
    do_reset();
    run(32'h002081B3, 0, 1'b0);
    run(32'h00000013, 0, 1'b0);
    run(32'h123452B7, 0, 1'b0);
    run(32'h0080A283, 3, 1'b0);
    run(32'h0080A283, 0, 1'b0);
    run(32'h0020A223, 1, 1'b0);
    run(32'h0020A223, 0, 1'b0);
    run(32'h00208463, 0, 1'b1);
    run(32'h00208463, 0, 1'b0);
    run(32'h00209463, 0, 1'b0);
    run(32'h00209463, 0, 1'b1);
    run(32'h010000EF, 0, 1'b0);
    run(32'h022081B3, 0, 1'b0);
    do_reset();
    run(32'hFFFFFFFF, 0, 1'b0);
    do_reset();
    run(32'h002081B3, 2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
